// File: rtl/rb2_pkg.sv
// Shared state encoding and default geometry for the rb2 register-bank burst initiator.
package rb2_pkg;

  localparam int DEFAULT_WORD_WIDTH = 18;
  localparam int DEFAULT_WORD_DEPTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/rb2_rd_skid.sv
// Two-entry first-word-fall-through FIFO of {last, data} that buffers RAM read words
// so the consumer can stall without losing the word already in flight.
module rb2_rd_skid
  import rb2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WORD_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             push_last,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic             head_last,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  entry_t     wr_entry;
  entry_t     head_entry;
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic       stored_any;
  logic       store;
  logic       deq;

  assign wr_entry   = {push_last, push_data};
  assign stored_any = (count_q != 2'd0);

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    mem_d      = mem_q;
    head_entry = stored_any ? mem_q[rd_ptr_q] : wr_entry;
    deq        = pop && stored_any;
    // A word that falls through an empty FIFO and is popped at once never lands.
    store      = push && !(pop && !stored_any);
    if (store) begin
      mem_d[wr_ptr_q] = wr_entry;
    end
    wr_ptr_d = wr_ptr_q ^ store;
    rd_ptr_d = rd_ptr_q ^ deq;
    count_d  = count_q + {1'b0, store} - {1'b0, deq};
  end

  assign head_valid = stored_any || push;
  assign head_last  = head_valid && head_entry.last;
  assign head_data  = head_entry.data;
  assign count      = count_q;

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (RST) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: payload storage is deliberately not reset; count_q alone decides validity.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rb2_burst_ctrl.sv
// Burst initiator for the 8x18 single-port register-bank RAM: streams write bursts in and
// read bursts out over valid/ready, hiding the RAM's one-cycle registered read latency.
module rb2_burst_ctrl
  import rb2_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int WORD_DEPTH = DEFAULT_WORD_DEPTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [WORD_WIDTH-1:0] wd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  done,
  output logic                  busy,
  output logic                  mem_WENn,
  output logic [ADDR_WIDTH-1:0] mem_A,
  output logic [WORD_WIDTH-1:0] mem_D,
  input  logic [WORD_WIDTH-1:0] mem_Q
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] a_hold_q, a_hold_d;
  logic                  done_q, done_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;

  logic                  addr_active;
  logic                  wd_fire;
  logic                  rd_fire;
  logic                  issue;
  logic                  issue_last;
  logic                  fifo_push;
  logic [1:0]            fifo_count;
  logic [2:0]            occupancy;
  logic                  head_valid;
  logic                  head_last;
  logic [WORD_WIDTH-1:0] head_data;

  // Explicit wrap so a non-power-of-two depth still cycles through valid words only.
  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + ONE;
  endfunction

  assign cmd_ready   = (state_q == ST_IDLE) && !RST;
  assign wd_ready    = (state_q == ST_WRITE) && !RST;
  assign wd_fire     = wd_ready && wd_valid;
  assign addr_active = (state_q == ST_WRITE) || (state_q == ST_READ);

  assign mem_WENn = !wd_fire;
  assign mem_A    = addr_active ? ptr_q : a_hold_q;
  assign mem_D    = (state_q == ST_WRITE) ? wd_data : '0;

  assign rd_valid = head_valid;
  assign rd_data  = head_data;
  assign rd_last  = head_last;
  assign rd_fire  = rd_valid && rd_ready;

  assign done = done_q;
  assign busy = (state_q != ST_IDLE);

  // Issue only if the word would still have a FIFO slot once it returns next cycle.
  assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, rd_fire};
  assign issue      = (state_q == ST_READ) && !RST && (occupancy < 3'd2);
  assign issue_last = issue && (cnt_q == '0);
  assign fifo_push  = inflight_q && !RST;

  rb2_rd_skid #(
    .WIDTH(WORD_WIDTH)
  ) u_skid (
    .CLK       (CLK),
    .RST       (RST),
    .push      (fifo_push),
    .push_last (inflight_last_q),
    .push_data (mem_Q),
    .pop       (rd_fire),
    .head_valid(head_valid),
    .head_last (head_last),
    .head_data (head_data),
    .count     (fifo_count)
  );

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    cnt_d           = cnt_q;
    done_d          = 1'b0;
    a_hold_d        = mem_A;
    inflight_d      = issue;
    inflight_last_d = issue_last;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          ptr_d   = cmd_addr;
          cnt_d   = cmd_len;
          state_d = cmd_wr ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        if (wd_fire) begin
          ptr_d = ptr_inc(ptr_q);
          cnt_d = cnt_q - ONE;
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (issue) begin
          ptr_d = ptr_inc(ptr_q);
          cnt_d = cnt_q - ONE;
          if (issue_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (rd_fire && rd_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q         <= ST_IDLE;
      ptr_q           <= '0;
      cnt_q           <= '0;
      a_hold_q        <= '0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      cnt_q           <= cnt_d;
      a_hold_q        <= a_hold_d;
      done_q          <= done_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

endmodule

// File: doc/rb2_burst_ctrl.md
Name: rb2_burst_ctrl

Overview:
- Initiator that drives the port of the 8x18 single-port register-bank RAM: CLK, active-low write enable WENn, address A, write data D, registered read data Q.
- Accepts burst commands, up to WORD_DEPTH words, with a start address and a direction.
- Write bursts stream data in over a valid/ready channel; read bursts stream data out over a valid/ready channel with backpressure.
- Hides the RAM's 1-cycle read latency from the consumer. Sits between datapath logic and one RAM instance.

Parameters:
- WORD_WIDTH, 18, data width; must match the RAM.
- WORD_DEPTH, 8, number of RAM words; must be <= 2**ADDR_WIDTH.
- ADDR_WIDTH, 3, address and length field width.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE and not in reset.
- cmd_wr  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  start address.
- cmd_len  in  ADDR_WIDTH  burst length minus 1 (0 means 1 word).
- wd_valid  in  1  write data offered.
- wd_ready  out  1  write word accepted this cycle.
- wd_data  in  WORD_WIDTH  write word.
- rd_valid  out  1  read word available.
- rd_ready  in  1  consumer accepts the read word.
- rd_data  out  WORD_WIDTH  read word.
- rd_last  out  1  qualifies the final word of a read burst.
- done  out  1  one-cycle pulse at burst completion.
- busy  out  1  high whenever state != IDLE.
- mem_WENn  out  1  to RAM WENn; 0 = write.
- mem_A  out  ADDR_WIDTH  to RAM A.
- mem_D  out  WORD_WIDTH  to RAM D.
- mem_Q  in  WORD_WIDTH  from RAM Q; valid the cycle after a read issue.

Behaviour:
- Reset values: state IDLE, cmd_ready 0 during reset, wd_ready 0, rd_valid 0, rd_last 0, done 0, busy 0, mem_WENn 1, mem_A 0, mem_D 0. Output buffer and in-flight flag cleared.
- mem_WENn is combinationally forced to 1 while RST is high, so no RAM write occurs in a reset cycle.
- States: IDLE, WRITE, READ, DRAIN.
- Command handshake:
  - Fires when cmd_valid && cmd_ready.
  - Latch addr into the pointer and len into the remaining count.
  - Go to WRITE if cmd_wr, else READ.
  - Commands are never accepted outside IDLE.
- WRITE:
  - wd_ready = 1.
  - mem_WENn = !wd_valid, mem_A = pointer, mem_D = wd_data, all combinational.
  - Each wd handshake writes that cycle, increments the pointer and decrements the count.
  - On the handshake with count == 0: done = 1 in the next cycle, return to IDLE.
  - Throughput is 1 word per cycle. wd_valid low means an idle cycle with mem_WENn = 1.
- READ:
  - mem_WENn = 1, mem_A = pointer.
  - A read is issued in a cycle when (buffer entries + in-flight - pop_this_cycle) < 2. On issue, the pointer advances and the count decrements.
  - The in-flight word is captured from mem_Q the next cycle into a 2-entry FIFO, tagged last if it was the final issue.
  - After the final issue, go to DRAIN.
- DRAIN:
  - No issues.
  - When the last-tagged word is accepted (rd_valid && rd_ready && rd_last): done = 1 next cycle, return to IDLE.
- Read output:
  - rd_data/rd_valid/rd_last come from the FIFO head.
  - Once rd_valid rises, rd_data must stay stable until accepted.
  - With rd_ready held high, read throughput is 1 word per cycle after a 2-cycle initial latency (command accept cycle, then issue, then data).
- Pointer wrap: after WORD_DEPTH-1 the pointer goes to 0, implemented by explicit compare, not by overflow. Example: addr 6, len 3 accesses 6, 7, 0, 1.
- mem_A holds its last value when idle. mem_D is don't-care when mem_WENn = 1.
- done is high for exactly one cycle per burst. busy is low in the cycle done is high.
- Simultaneous capture and pop on the FIFO is legal and keeps the count unchanged.
- Reset mid-burst: abandon the burst and flush the FIFO. Words already written stay in RAM. No done pulse.

Decomposition:
- Shared package rb2_pkg holds:
  - the state encoding constants (IDLE, WRITE, READ, DRAIN);
  - the defaults WORD_WIDTH = 18, WORD_DEPTH = 8, ADDR_WIDTH = 3.
- One sub-module: rb2_rd_skid, a 2-entry FIFO of {last, data} with push/pop/count. Everything else is inline.

Test Plan:
- Write burst: cmd_wr=1, addr=2, len=3, data 0x00011, 0x00022, 0x00033, 0x00044 with wd_valid continuous -> RAM cells 2..5 written on 4 consecutive cycles; done pulses once; cmd_ready returns high.
- Read-back: read burst addr=2, len=3, rd_ready=1 -> rd_data 0x00011, 0x00022, 0x00033, 0x00044 on consecutive cycles; rd_last only on 0x00044; first rd_valid 2 cycles after the command accept.
- Wrap: write addr=6, len=3 with 0x3FFFF, 0x00001, 0x00002, 0x00003, then read addr=6, len=3 -> same sequence returned; cells 6, 7, 0, 1 hold them.
- Backpressure: read len=7 with rd_ready toggling 1,0,0,1 -> no word lost or duplicated; rd_data stable while stalled; FIFO never exceeds 2 entries.
- Write gaps: wd_valid low on alternate cycles -> mem_WENn=1 in gap cycles; the pointer does not advance in gaps.
- Reset mid-burst: assert RST in the 3rd cycle of a len=7 write -> no write in the reset cycle; after reset all outputs are at reset values, no done pulse, and the next command is accepted normally.
